snn_tick_scheduler: RTL and testbench
=====================================

// Module: snn_tick_scheduler
// PURPOSE
//  Timestep sequencer for the single-core SNN grid, in the sys_clk domain on the host side of the CDC FIFOs.
//  Takes a host stream of input packets, one burst per timestep delimited by s_last.
//  Forwards each burst into the packet FIFO, then waits for tick_ready and pulses tick.
//  Repeats this for a programmed number of timesteps.
//  Watches the core error flags and stops in a sticky ERROR state if either one rises.
// PARAMETERS
//  TICK_CNT_W   16    width of num_ticks / ticks_done
//  PKT_CNT_W    16    width of per-tick packet counter (saturating)
//  TICK_PULSE   2     cycles tick is held high (>=1)
//  SETTLE_CYC   8     cycles waited after tick before tick_ready is sampled again (>=1)
//  TIMEOUT      4096  max cycles in WAIT_READY before timeout error (0 = disabled)
// PORTS
//  clk            in   1           clock (sys_clk domain)
//  reset          in   1           asynchronous, active-high reset
//  start          in   1           1-cycle pulse: latch num_ticks, begin run
//  clear          in   1           1-cycle pulse: leave ERROR/DONE, return to IDLE
//  num_ticks      in   TICK_CNT_W  timesteps to run
//  s_valid        in   1           host packet valid
//  s_data         in   30          host packet
//  s_last         in   1           last packet of current timestep (qualified by s_valid)
//  s_ready        out  1           scheduler accepts packet
//  packet_winc    out  1           write strobe to packet FIFO
//  packet_wdata   out  30          packet to packet FIFO
//  packet_wfull   in   1           packet FIFO full
//  tick           out  1           tick to grid wrapper
//  tick_ready     in   1           core ready for next tick (pre-synchronised to clk)
//  core_err       in   2           {scheduler_error, token_controller_error}, pre-synchronised
//  busy           out  1           run in progress
//  done           out  1           level: run completed
//  ticks_done     out  TICK_CNT_W  timesteps issued in current run
//  pkt_cnt        out  PKT_CNT_W   packets forwarded in current timestep
//  err            out  1           sticky error flag
//  err_code       out  2           01 core error, 10 WAIT_READY timeout, 00 none
// BEHAVIOUR
//  Reset: state IDLE.
//   All outputs are 0: s_ready, packet_winc, tick, busy, done, err, err_code, ticks_done, pkt_cnt.
//  States: IDLE, LOAD, WAIT_READY, TICK, SETTLE, DONE, ERROR.
//  IDLE/DONE:
//   - start latches num_ticks, clears ticks_done, pkt_cnt, done.
//   - num_ticks==0 -> DONE next cycle; else -> LOAD.
//   - start is ignored in all other states.
//  LOAD:
//   - s_ready = ~packet_wfull, combinational.
//   - Transfer when s_valid&s_ready: packet_winc=1, packet_wdata=s_data in the same cycle (zero latency).
//   - packet_winc is never asserted while packet_wfull=1.
//   - pkt_cnt increments on each transfer and saturates at all-ones.
//   - Transfer with s_last=1 -> WAIT_READY.
//   - An empty timestep is a single beat with s_last=1; that beat is still forwarded.
//  WAIT_READY:
//   - s_ready=0; a wait counter runs.
//   - tick_ready=1 -> TICK.
//   - Counter reaching TIMEOUT (TIMEOUT!=0) -> ERROR with err_code=10.
//  TICK: tick=1 for exactly TICK_PULSE cycles, then SETTLE.
//  SETTLE:
//   - tick=0; wait SETTLE_CYC cycles, then ticks_done+1 and pkt_cnt cleared.
//   - ticks_done==num_ticks -> DONE, else -> LOAD.
//  DONE: done=1, busy=0. busy=1 in LOAD, WAIT_READY, TICK, SETTLE.
//  Error: any core_err bit high in LOAD, WAIT_READY, TICK or SETTLE -> ERROR next cycle, err=1, err_code=01.
//   - core_err has priority over the timeout and over any state transition in the same cycle.
//   - A packet transfer in that same cycle is still completed.
//  ERROR: s_ready=0, tick=0 (a tick pulse is truncated), busy=0. err and err_code hold until clear.
//  clear: -> IDLE from ERROR or DONE; err, err_code, done, ticks_done, pkt_cnt reset to 0. Ignored elsewhere.
//  clear and start in the same cycle: clear wins.
//  Reset mid-run: immediate return to reset values. No partial tick pulse survives reset.
// TESTING
//  T1 num_ticks=3, 4 packets/tick, tick_ready held 1:
//     -> 12 packet_winc, 3 tick pulses of 2 cycles each, ticks_done=3, done=1.
//  T2 packet_wfull=1 for 5 cycles mid-burst:
//     -> s_ready=0 and packet_winc=0 for those cycles; no packet lost or duplicated, data order kept.
//  T3 tick_ready=0 for 100 cycles after the burst:
//     -> tick stays 0 until tick_ready rises, then pulses.
//     -> With TIMEOUT=64: ERROR and err_code=10 after 64 cycles.
//  T4 core_err=2'b01 during SETTLE of tick 2 of 5:
//     -> ERROR, err_code=01, ticks_done=1, tick stays 0.
//     -> start ignored; clear -> IDLE with all outputs 0.
//  T5 start with num_ticks=0 -> DONE after 1 cycle, no tick and no packet_winc.
//     Single-beat s_last timestep -> 1 write, pkt_cnt=1, then tick.
//  T6 reset asserted during TICK -> tick=0 and all outputs at reset values within 1 cycle.
//     A subsequent start runs normally.

Source files
------------

// File: rtl/snn_tick_scheduler.sv
// rtl/snn_tick_scheduler.sv - timestep sequencer: host burst -> packet FIFO, then tick handshake
`timescale 1ns/1ps
module snn_tick_scheduler #(
  parameter int TICK_CNT_W = 16,
  parameter int PKT_CNT_W  = 16,
  parameter int TICK_PULSE = 2,
  parameter int SETTLE_CYC = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  input  logic [TICK_CNT_W-1:0] num_ticks,
  input  logic                  s_valid,
  input  logic [29:0]           s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  packet_winc,
  output logic [29:0]           packet_wdata,
  input  logic                  packet_wfull,
  output logic                  tick,
  input  logic                  tick_ready,
  input  logic [1:0]            core_err,
  output logic                  busy,
  output logic                  done,
  output logic [TICK_CNT_W-1:0] ticks_done,
  output logic [PKT_CNT_W-1:0]  pkt_cnt,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int CW = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_TICK, S_SETTLE, S_DONE, S_ERROR
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [TICK_CNT_W-1:0] num_q, num_n, ticks_n, ticks_inc;
  logic [PKT_CNT_W-1:0]  pkt_n;
  logic                  err_n;
  logic [1:0]            code_n;

  // Packets pass straight through; only the strobe qualifies them.
  assign packet_wdata = s_data;
  assign ticks_inc    = ticks_done + 1'b1;

  // State and datapath registers; async reset drops tick immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      num_q      <= '0;
      ticks_done <= '0;
      pkt_cnt    <= '0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      num_q      <= num_n;
      ticks_done <= ticks_n;
      pkt_cnt    <= pkt_n;
      err        <= err_n;
      err_code   <= code_n;
    end
  end

  // Next-state, next-datapath and Moore/handshake outputs.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    num_n       = num_q;
    ticks_n     = ticks_done;
    pkt_n       = pkt_cnt;
    err_n       = err;
    code_n      = err_code;
    s_ready     = (state == S_LOAD) && !packet_wfull;
    packet_winc = s_ready && s_valid;
    tick        = (state == S_TICK);
    done        = (state == S_DONE);
    busy        = (state == S_LOAD) || (state == S_WAIT) ||
                  (state == S_TICK) || (state == S_SETTLE);

    case (state)
      S_IDLE, S_DONE: begin
        if (clear) begin
          state_n = S_IDLE;
          ticks_n = '0;
          pkt_n   = '0;
        end else if (start) begin
          num_n   = num_ticks;
          ticks_n = '0;
          pkt_n   = '0;
          cnt_n   = '0;
          state_n = (num_ticks == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (packet_winc) begin
          if (pkt_cnt != '1) pkt_n = pkt_cnt + 1'b1;
          if (s_last) begin
            state_n = S_WAIT;
            cnt_n   = '0;
          end
        end
      end
      S_WAIT: begin
        cnt_n = cnt + 1'b1;
        if (tick_ready) begin
          state_n = S_TICK;
          cnt_n   = '0;
        end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
          state_n = S_ERROR;
          err_n   = 1'b1;
          code_n  = 2'b10;
        end
      end
      S_TICK: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(TICK_PULSE - 1)) begin
          state_n = S_SETTLE;
          cnt_n   = '0;
        end
      end
      S_SETTLE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(SETTLE_CYC - 1)) begin
          cnt_n   = '0;
          ticks_n = ticks_inc;
          pkt_n   = '0;
          state_n = (ticks_inc == num_q) ? S_DONE : S_LOAD;
        end
      end
      S_ERROR: begin
        if (clear) begin
          state_n = S_IDLE;
          err_n   = 1'b0;
          code_n  = 2'b00;
          ticks_n = '0;
          pkt_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Core error overrides any transition, but a same-cycle transfer still counts.
    if (busy && (|core_err)) begin
      state_n = S_ERROR;
      err_n   = 1'b1;
      code_n  = 2'b01;
      ticks_n = ticks_done;
      if (state != S_LOAD) pkt_n = pkt_cnt;
    end
  end

endmodule

// File: tb/tb_snn_tick_scheduler.sv
// tb/tb_snn_tick_scheduler.sv - self-checking bench for snn_tick_scheduler
`timescale 1ns/1ps
module tb_snn_tick_scheduler;

  logic        clk, reset, start, clear, s_valid, s_last, packet_wfull, tick_ready;
  logic [15:0] num_ticks;
  logic [29:0] s_data;
  logic [1:0]  core_err;
  logic        s_ready, packet_winc, tick, busy, done, err;
  logic [29:0] packet_wdata;
  logic [15:0] ticks_done, pkt_cnt;
  logic [1:0]  err_code;
  logic        s_ready2, winc2, tick2, busy2, done2, err2;
  logic [29:0] wdata2;
  logic [15:0] ticks_done2, pkt_cnt2;
  logic [1:0]  err_code2;

  snn_tick_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .num_ticks(num_ticks),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .packet_winc(packet_winc), .packet_wdata(packet_wdata), .packet_wfull(packet_wfull),
    .tick(tick), .tick_ready(tick_ready), .core_err(core_err), .busy(busy), .done(done),
    .ticks_done(ticks_done), .pkt_cnt(pkt_cnt), .err(err), .err_code(err_code));

  snn_tick_scheduler #(.TIMEOUT(64)) dut_to (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .num_ticks(num_ticks),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready2),
    .packet_winc(winc2), .packet_wdata(wdata2), .packet_wfull(packet_wfull),
    .tick(tick2), .tick_ready(tick_ready), .core_err(core_err), .busy(busy2), .done(done2),
    .ticks_done(ticks_done2), .pkt_cnt(pkt_cnt2), .err(err2), .err_code(err_code2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int win_cnt = 0;
  int tick_cnt = 0;
  int hi_len = 0;
  logic [29:0] exp_q[$];

  typedef struct {
    int num;
    int pkts;
    int exp_writes;
    int exp_ticks;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard and tick-shape monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      hi_len = 0;
    end else begin
      if (packet_winc) begin
        win_cnt++;
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else chk("wdata", int'(packet_wdata), int'(exp_q.pop_front()));
      end
      if (packet_wfull) chk("winc_while_full", int'(packet_winc), 0);
      if (tick) begin
        if (hi_len == 0) tick_cnt++;
        hi_len++;
      end else if (hi_len != 0) begin
        chk("tick_width", hi_len, 2);
        hi_len = 0;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; start = 0; clear = 0; num_ticks = '0; s_valid = 0; s_data = '0;
    s_last = 0; packet_wfull = 0; tick_ready = 1; core_err = 2'b00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_start(input int n);
    num_ticks = 16'(n);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_burst(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      int k;
      bit ok;
      s_valid = 1'b1;
      s_data  = 30'(base + i);
      s_last  = (i == n - 1);
      exp_q.push_back(30'(base + i));
      ok = 0;
      for (k = 0; k < 2000 && !ok; k++) begin
        @(negedge clk);
        if (s_ready) ok = 1;
      end
      if (!ok) chk("s_ready_wait", 0, 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    if (!ok) chk("done_wait", 0, 1);
  endtask

  task automatic wait_tick(input logic lvl);
    bit ok = 0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (tick == lvl) ok = 1;
    end
    if (!ok) chk("tick_wait", 0, 1);
  endtask

  task automatic run_ticks(input int num, input int pkts, input int base);
    pulse_start(num);
    for (int t = 0; t < num; t++) send_burst(pkts, base + t * 16);
    wait_done();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_s_ready"}, int'(s_ready), 0);
    chk({tag, "_winc"}, int'(packet_winc), 0);
    chk({tag, "_tick"}, int'(tick), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_err_code"}, int'(err_code), 0);
    chk({tag, "_ticks_done"}, int'(ticks_done), 0);
    chk({tag, "_pkt_cnt"}, int'(pkt_cnt), 0);
  endtask

  initial begin
    int w0, t0;
    bit seen;
    vecs[0] = '{num: 3, pkts: 4, exp_writes: 12, exp_ticks: 3};
    vecs[1] = '{num: 2, pkts: 1, exp_writes: 2,  exp_ticks: 2};
    vecs[2] = '{num: 0, pkts: 3, exp_writes: 0,  exp_ticks: 0};
    vecs[3] = '{num: 1, pkts: 6, exp_writes: 6,  exp_ticks: 1};

    do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Table-driven full runs, each finished by a simultaneous clear+start.
    for (int i = 0; i < 4; i++) begin
      w0 = win_cnt; t0 = tick_cnt;
      run_ticks(vecs[i].num, vecs[i].pkts, 'h1000 * (i + 1));
      chk("run_writes", win_cnt - w0, vecs[i].exp_writes);
      chk("run_ticks", tick_cnt - t0, vecs[i].exp_ticks);
      chk("run_ticks_done", int'(ticks_done), vecs[i].num);
      chk("run_done", int'(done), 1);
      chk("run_busy", int'(busy), 0);
      chk("run_pkt_cnt", int'(pkt_cnt), 0);
      num_ticks = 16'd2; start = 1'b1; clear = 1'b1;
      @(posedge clk); #1 start = 1'b0; clear = 1'b0;
      @(negedge clk);
      chk("clear_wins_busy", int'(busy), 0);
      chk("clear_wins_done", int'(done), 0);
      chk("clear_ticks_done", int'(ticks_done), 0);
    end

    // FIFO full for 5 cycles in the middle of a burst.
    do_reset();
    w0 = win_cnt;
    pulse_start(1);
    fork
      send_burst(8, 'h2000);
      begin
        repeat (3) @(posedge clk);
        #1 packet_wfull = 1'b1;
        repeat (5) begin
          @(negedge clk);
          chk("full_s_ready", int'(s_ready), 0);
          chk("full_winc", int'(packet_winc), 0);
        end
        @(posedge clk); #1 packet_wfull = 1'b0;
      end
    join
    wait_done();
    chk("full_writes", win_cnt - w0, 8);
    chk("full_queue_empty", exp_q.size(), 0);

    // tick_ready held low for 100 cycles; the TIMEOUT=64 copy must time out.
    do_reset();
    tick_ready = 1'b0;
    t0 = tick_cnt;
    pulse_start(1);
    send_burst(3, 'h3000);
    seen = 0;
    repeat (64) begin
      @(negedge clk);
      if (tick) seen = 1;
    end
    chk("to_err_before", int'(err2), 0);
    @(negedge clk);
    chk("to_err_after", int'(err2), 1);
    chk("to_err_code", int'(err_code2), 2);
    chk("to_busy", int'(busy2), 0);
    repeat (35) begin
      @(negedge clk);
      if (tick) seen = 1;
    end
    chk("wait_no_tick", int'(seen), 0);
    chk("wait_busy", int'(busy), 1);
    chk("wait_no_err", int'(err), 0);
    #1 tick_ready = 1'b1;
    wait_tick(1'b1);
    wait_done();
    chk("wait_ticks", tick_cnt - t0, 1);

    // Core error during SETTLE of tick 2 of 5.
    do_reset();
    pulse_start(5);
    send_burst(2, 'h4000);
    send_burst(2, 'h4100);
    wait_tick(1'b1);
    wait_tick(1'b0);
    #1 core_err = 2'b01;
    @(posedge clk); #1 core_err = 2'b00;
    @(negedge clk);
    chk("cerr_err", int'(err), 1);
    chk("cerr_code", int'(err_code), 1);
    chk("cerr_ticks_done", int'(ticks_done), 1);
    chk("cerr_busy", int'(busy), 0);
    pulse_start(3);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (tick || busy || s_ready) seen = 1;
    end
    chk("cerr_quiet", int'(seen), 0);
    chk("cerr_start_ignored", int'(err), 1);
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk_idle_outputs("cleared");

    // num_ticks=0 goes to DONE one cycle after start, without writes or ticks.
    do_reset();
    w0 = win_cnt; t0 = tick_cnt;
    pulse_start(0);
    @(negedge clk);
    chk("zero_done", int'(done), 1);
    repeat (5) @(negedge clk);
    chk("zero_writes", win_cnt - w0, 0);
    chk("zero_ticks", tick_cnt - t0, 0);

    // Single-beat timestep still forwarded and counted.
    do_reset();
    tick_ready = 1'b0;
    w0 = win_cnt;
    pulse_start(1);
    send_burst(1, 'h3ff);
    @(negedge clk);
    chk("single_pkt_cnt", int'(pkt_cnt), 1);
    chk("single_writes", win_cnt - w0, 1);
    #1 tick_ready = 1'b1;
    wait_tick(1'b1);
    wait_done();
    chk("single_ticks_done", int'(ticks_done), 1);

    // Reset asserted in the middle of a tick pulse.
    do_reset();
    pulse_start(2);
    send_burst(2, 'h5000);
    wait_tick(1'b1);
    #1 reset = 1'b1;
    #1;
    chk_idle_outputs("midreset");
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    t0 = tick_cnt;
    run_ticks(1, 2, 'h6000);
    chk("after_reset_ticks", tick_cnt - t0, 1);
    chk("after_reset_ticks_done", int'(ticks_done), 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
